// File: rtl/multiplier_control.sv
// multiplier_control: sequencer for a Booth-style add/shift multiplier datapath.
// Walks N_BITS ADD/SHIFT pairs per Run request, subtracting on the final
// (sign) bit, and raises Done until Run is released.
// Optional build macro MULT_CTRL_AUTO_CLEAR_EN inserts a CLR state that
// zeroes A/X before every multiplication; without it, consecutive Runs
// accumulate into A.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for Run; ClearA_LoadB produces a same-cycle Clr_Ld
// S_CLR   | (macro only) one-cycle Clear_AX before the first ADD
// S_ADD   | Add (or Sub on the last iteration) gated by multiplier bit M
// S_SHIFT | one arithmetic right shift of X:A:B, advance or finish
// S_DONE  | result ready; hold until Run drops, never restart from here
module multiplier_control #(
    parameter int N_BITS = 8
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      Run,
    input  logic                      ClearA_LoadB,
    input  logic                      M,
    output logic                      Clr_Ld,
    output logic                      Clear_AX,
    output logic                      Add,
    output logic                      Sub,
    output logic                      Shift,
    output logic                      Busy,
    output logic                      Done,
    output logic [$clog2(N_BITS)-1:0] Iter
);

    localparam int              IW        = $clog2(N_BITS);
    localparam logic [IW-1:0]   ITER_LAST = IW'(N_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
`ifdef MULT_CTRL_AUTO_CLEAR_EN
        S_CLR   = 3'd1,
`endif
        S_ADD   = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   iter, iter_nxt;
    logic            clr_ld, add, sub, shift, busy, done;
`ifdef MULT_CTRL_AUTO_CLEAR_EN
    logic            clear_ax;
`endif

    // State and iteration counter registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= S_IDLE;
            iter  <= '0;
        end else begin
            state <= state_nxt;
            iter  <= iter_nxt;
        end
    end

    // Next-state, counter update and raw strobe decode.
    always_comb begin
        state_nxt = state;
        iter_nxt  = iter;
        clr_ld    = 1'b0;
        add       = 1'b0;
        sub       = 1'b0;
        shift     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
`ifdef MULT_CTRL_AUTO_CLEAR_EN
        clear_ax  = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                iter_nxt = '0;
                if (Run) begin
`ifdef MULT_CTRL_AUTO_CLEAR_EN
                    state_nxt = S_CLR;
`else
                    state_nxt = S_ADD;
`endif
                end else if (ClearA_LoadB) begin
                    clr_ld = 1'b1;
                end
            end
`ifdef MULT_CTRL_AUTO_CLEAR_EN
            S_CLR: begin
                busy      = 1'b1;
                clear_ax  = 1'b1;
                state_nxt = S_ADD;
            end
`endif
            S_ADD: begin
                busy = 1'b1;
                // The last multiplier bit carries negative weight.
                if (iter == ITER_LAST) begin
                    sub = M;
                end else begin
                    add = M;
                end
                state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                busy  = 1'b1;
                shift = 1'b1;
                if (iter == ITER_LAST) begin
                    state_nxt = S_DONE;
                    iter_nxt  = '0;
                end else begin
                    state_nxt = S_ADD;
                    iter_nxt  = iter + IW'(1);
                end
            end
            S_DONE: begin
                done     = 1'b1;
                iter_nxt = '0;
                if (!Run) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                iter_nxt  = '0;
            end
        endcase
    end

    // Outputs are forced low while Reset is held, independent of state.
    assign Clr_Ld = clr_ld & ~Reset;
    assign Add    = add    & ~Reset;
    assign Sub    = sub    & ~Reset;
    assign Shift  = shift  & ~Reset;
    assign Busy   = busy   & ~Reset;
    assign Done   = done   & ~Reset;
    assign Iter   = iter;
`ifdef MULT_CTRL_AUTO_CLEAR_EN
    assign Clear_AX = clear_ax & ~Reset;
`else
    assign Clear_AX = 1'b0;
`endif

endmodule

// File: tb/tb_multiplier_control.sv
// Directed bench for multiplier_control (N_BITS = 8), adapting its expected
// CLR behaviour to whether MULT_CTRL_AUTO_CLEAR_EN is defined.
module tb_multiplier_control;

    localparam int N = 8;
`ifdef MULT_CTRL_AUTO_CLEAR_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic       Clk = 1'b0;
    logic       Reset, Run, ClearA_LoadB, M;
    logic       Clr_Ld, Clear_AX, Add, Sub, Shift, Busy, Done;
    logic [2:0] Iter;
    logic [6:0] outs;

    int checks = 0;
    int errors = 0;

    // Per-sequence observations gathered by run_seq.
    int done_cyc, busy_cnt, shift_cnt, add_cnt, sub_cnt, clrld_cnt;
    int clrax_cnt, clrax_first, overlap_cnt, add_mask, sub_mask;
    int hold_ok, found;
    logic [2:0] iter_at_done;

    multiplier_control #(.N_BITS(N)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Run          (Run),
        .ClearA_LoadB (ClearA_LoadB),
        .M            (M),
        .Clr_Ld       (Clr_Ld),
        .Clear_AX     (Clear_AX),
        .Add          (Add),
        .Sub          (Sub),
        .Shift        (Shift),
        .Busy         (Busy),
        .Done         (Done),
        .Iter         (Iter)
    );

    assign outs = {Clr_Ld, Clear_AX, Add, Sub, Shift, Busy, Done};

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Request one multiplication with a constant multiplier bit and observe
    // every cycle until Done (bounded). Leaves Run high in DONE.
    task automatic run_seq(input logic m_val);
        int cyc;
        done_cyc = 0; busy_cnt = 0; shift_cnt = 0; add_cnt = 0; sub_cnt = 0;
        clrld_cnt = 0; clrax_cnt = 0; clrax_first = 0; overlap_cnt = 0;
        add_mask = 0; sub_mask = 0; iter_at_done = 3'd7;
        Run = 1'b1;
        M   = m_val;
        cyc = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            cyc++;
            if (Busy) busy_cnt++;
            if (Shift) shift_cnt++;
            if (Clr_Ld) clrld_cnt++;
            if (Add) begin add_cnt++; add_mask |= (1 << Iter); end
            if (Sub) begin sub_cnt++; sub_mask |= (1 << Iter); end
            if (Clear_AX) begin
                clrax_cnt++;
                if (clrax_first == 0) clrax_first = cyc;
            end
            if ($countones({Clr_Ld, Clear_AX, Add, Sub, Shift}) > 1) overlap_cnt++;
            if (Done) begin
                done_cyc = cyc;
                iter_at_done = Iter;
                break;
            end
        end
    endtask

    initial begin
        Reset = 1'b1; Run = 1'b0; ClearA_LoadB = 1'b1; M = 1'b0;

        // Reset: outputs low while Reset is held, even with requests present.
        tick();
        chk("reset_outs_clb", outs, 0);
        Run = 1'b1;
        #1;
        chk("reset_outs_run", outs, 0);
        chk("reset_iter", Iter, 0);
        Run = 1'b0;
        tick();
        Reset = 1'b0; ClearA_LoadB = 1'b0;
        #1;
        chk("idle_outs", outs, 0);
        tick();
        chk("idle_outs_2", outs, 0);

        // M = 0 throughout: shifts only.
        run_seq(1'b0);
        chk("m0_done_cyc", done_cyc, 2*N + 1 + EXTRA);
        chk("m0_busy_cnt", busy_cnt, 2*N + EXTRA);
        chk("m0_shift_cnt", shift_cnt, N);
        chk("m0_add_cnt", add_cnt, 0);
        chk("m0_sub_cnt", sub_cnt, 0);
        chk("m0_iter_done", iter_at_done, 0);
        chk("m0_clrax_cnt", clrax_cnt, EXTRA);
`ifdef MULT_CTRL_AUTO_CLEAR_EN
        chk("m0_clrax_first", clrax_first, 1);
`endif
        chk("m0_overlap", overlap_cnt, 0);

        // Run held through DONE: no restart.
        hold_ok = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (Done && !Busy && !Shift && !Add && !Sub) hold_ok++;
        end
        chk("hold_done_cycles", hold_ok, 5);
        Run = 1'b0;
        tick();
        chk("release_idle", outs, 0);

        // Clr_Ld is a same-cycle Mealy output; Run takes priority.
        ClearA_LoadB = 1'b1;
        #1;
        chk("clr_ld_idle", outs, 7'b1000000);
        Run = 1'b1;
        #1;
        chk("clr_ld_run_prio", outs, 0);

        // M = 1 every iteration, ClearA_LoadB ignored while busy.
        run_seq(1'b1);
        chk("m1_add_mask", add_mask, 32'h7F);
        chk("m1_sub_mask", sub_mask, 32'h80);
        chk("m1_shift_cnt", shift_cnt, N);
        chk("m1_clrld_busy", clrld_cnt, 0);
        chk("m1_overlap", overlap_cnt, 0);
        chk("m1_done_cyc", done_cyc, 2*N + 1 + EXTRA);
        Run = 1'b0; ClearA_LoadB = 1'b0;
        tick();
        chk("m1_release_idle", outs, 0);

        // Reset in SHIFT at Iter = 3.
        Run = 1'b1; M = 1'b1;
        found = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (Shift && Iter == 3'd3) begin
                found = 1;
                break;
            end
        end
        chk("midrst_reached", found, 1);
        Reset = 1'b1; Run = 1'b0;
        #1;
        chk("midrst_outs_comb", outs, 0);
        tick();
        Reset = 1'b0;
        #1;
        chk("midrst_outs_after", outs, 0);
        chk("midrst_iter", Iter, 0);
        tick();
        chk("midrst_idle_stays", outs, 0);

        // A fresh Run after the mid-sequence reset completes normally.
        run_seq(1'b1);
        chk("post_rst_done_cyc", done_cyc, 2*N + 1 + EXTRA);
        chk("post_rst_add_mask", add_mask, 32'h7F);
        chk("post_rst_sub_mask", sub_mask, 32'h80);
        chk("post_rst_clrax", clrax_cnt, EXTRA);
        Run = 1'b0;
        tick();
        chk("final_idle", outs, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
